// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: start/busy/done handshake and operand/product bus for the multiplier
interface shift_add_multiplier_if #(parameter int WIDTH = 16);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: radix-2 shift-add unsigned multiplier built around a 4-bit-group CLA adder
module cla_adder #(parameter int WIDTH = 16) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o
);
  logic [WIDTH-1:0] g, p;
  logic [WIDTH:0]   c;
  assign g = x_i & y_i;
  assign p = x_i ^ y_i;
  // carries are resolved by lookahead inside each group and rippled between groups
  always_comb begin
    c = '0;
    c[0] = cin_i;
    for (int k = 0; k < WIDTH / 4; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end
  assign s_o    = p ^ c[WIDTH-1:0];
  assign cout_o = c[WIDTH];
endmodule

module shift_add_multiplier #(parameter int WIDTH = 16) (
  input  logic clk,
  input  logic rst,
  shift_add_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  cla_adder #(.WIDTH(WIDTH)) u_cla (
    .x_i(acc_q[2*WIDTH-1:WIDTH]),
    .y_i(mcand_q),
    .cin_i(1'b0),
    .s_o(sum),
    .cout_o(cout)
  );
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (state_q == RUN) begin
      acc_d = acc_q[0] ? {cout, sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:1]};
      cnt_d = cnt_q + 1'b1;
      product_d = (cnt_q == CW'(WIDTH - 1)) ? acc_d : product_q;
      state_d   = (cnt_q == CW'(WIDTH - 1)) ? DONE : RUN;
    end else if (bus.start) begin
      mcand_d = bus.a;
      acc_d   = {{WIDTH{1'b0}}, bus.b};
      cnt_d   = '0;
      state_d = RUN;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: table-driven and directed corner-case checks of the shift-add multiplier
module tb_shift_add_multiplier;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  shift_add_multiplier_if #(.WIDTH(16)) mif ();
  shift_add_multiplier #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(mif));
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;
  vec_t v[9];
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // waits (bounded) for done; returns busy cycles seen and cycles elapsed
  task automatic wait_done(output int nb, output int n);
    nb = 0;
    n = 0;
    while (!mif.done && n < 40) begin
      if (mif.busy) nb++;
      @(negedge clk);
      n++;
    end
  endtask
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp, input string nm);
    int nb, n;
    mif.a = a;
    mif.b = b;
    mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    mif.a = 16'h5a5a;
    mif.b = 16'ha5a5;
    wait_done(nb, n);
    check({nm, " done"}, 64'(mif.done), 64'd1);
    check({nm, " busy_cycles"}, 64'(nb), 64'd16);
    check({nm, " product"}, 64'(mif.product), 64'(exp));
    @(negedge clk);
    check({nm, " done_pulse"}, 64'(mif.done), 64'd0);
  endtask
  initial begin
    int nb, n, dones;
    v[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
    v[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    v[2] = '{16'h1234, 16'h0000, 32'h0000_0000};
    v[3] = '{16'h1234, 16'h0001, 32'h0000_1234};
    v[4] = '{16'h00FF, 16'h0100, 32'h0000_FF00};
    v[5] = '{16'h8000, 16'h0002, 32'h0001_0000};
    v[6] = '{16'hABCD, 16'h1000, 32'h0ABC_D000};
    v[7] = '{16'h8001, 16'h8001, 32'h4001_0001};
    v[8] = '{16'h0000, 16'hFFFF, 32'h0000_0000};
    rst = 1'b1;
    mif.start = 1'b0;
    mif.a = '0;
    mif.b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset busy", 64'(mif.busy), 64'd0);
    check("reset done", 64'(mif.done), 64'd0);
    check("reset product", 64'(mif.product), 64'd0);
    for (int i = 0; i < 9; i++) run_op(v[i].a, v[i].b, v[i].p, $sformatf("vec%0d", i));
    // start during RUN must be ignored and operands are latched
    mif.a = 16'd7;
    mif.b = 16'd9;
    mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (4) @(negedge clk);
    mif.a = 16'hFFFF;
    mif.b = 16'hFFFF;
    mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    wait_done(nb, n);
    check("ignore done", 64'(mif.done), 64'd1);
    check("ignore product", 64'(mif.product), 64'h3F);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (mif.done || mif.busy) dones++;
    end
    check("ignore no second op", 64'(dones), 64'd0);
    // back-to-back: start held through the done cycle
    mif.a = 16'h00FF;
    mif.b = 16'h0100;
    mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    wait_done(nb, n);
    check("b2b first product", 64'(mif.product), 64'hFF00);
    mif.a = 16'h8000;
    mif.b = 16'h0002;
    mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    check("b2b busy reasserts", 64'(mif.busy), 64'd1);
    wait_done(nb, n);
    check("b2b latency", 64'(n), 64'd16);
    check("b2b second product", 64'(mif.product), 64'h1_0000);
    @(negedge clk);
    // reset mid-run aborts and clears product
    mif.a = 16'h0010;
    mif.b = 16'h0010;
    mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 64'(mif.busy), 64'd0);
    check("abort done", 64'(mif.done), 64'd0);
    check("abort product", 64'(mif.product), 64'd0);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (mif.done || mif.busy) dones++;
    end
    check("abort no done", 64'(dones), 64'd0);
    run_op(16'd2, 16'd3, 32'd6, "after_abort");
    // reset wins over a simultaneous start
    mif.a = 16'd4;
    mif.b = 16'd4;
    mif.start = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mif.start = 1'b0;
    check("rst over start busy", 64'(mif.busy), 64'd0);
    check("rst over start product", 64'(mif.product), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
